prbs_frame_sequencer: RTL

PRBS_FRAME_SEQUENCER -- requirements
Module: prbs_frame_sequencer

---
 rtl/prbs_pkg.sv | 31 +++
 rtl/prbs15_byte_gen.sv | 33 +++
 rtl/prbs_frame_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS frame sequencer: FSM encodings,
// PRBS-15 tap positions, default header word and the 8-step LFSR helper.
package prbs_pkg;

  // Sparse 3-bit encoding so illegal codes exist and are recovered to IDLE
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_HEADER  = 3'b001,
    ST_PAYLOAD = 3'b010,
    ST_FINISH  = 3'b100
  } state_t;

  // PRBS-15: x^15 + x^14 + 1, feedback = s[14] ^ s[13]
  localparam int PRBS_LEN    = 15;
  localparam int PRBS_TAP_HI = 14;
  localparam int PRBS_TAP_LO = 13;

  localparam logic [31:0]         DEFAULT_PATTERN = 32'haabbccdd;
  localparam logic [PRBS_LEN-1:0] DEFAULT_SEED    = 15'h7fff;

  // Advance the LFSR by eight single-bit shifts (one payload byte)
  function automatic logic [PRBS_LEN-1:0] prbs15_advance8(input logic [PRBS_LEN-1:0] s);
    logic [PRBS_LEN-1:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = {t[PRBS_LEN-2:0], t[PRBS_TAP_HI] ^ t[PRBS_TAP_LO]};
    end
    return t;
  endfunction

endpackage

// File: rtl/prbs15_byte_gen.sv
// PRBS-15 byte generator. data_byte is the next eight serial output bits of
// the current state (first bit in bit 7); advance steps the LFSR eight times.
module prbs15_byte_gen
  import prbs_pkg::*;
#(
  parameter logic [PRBS_LEN-1:0] ResetSeed = DEFAULT_SEED
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load,
  input  logic                advance,
  input  logic [PRBS_LEN-1:0] seed,
  output logic [7:0]          data_byte
);

  logic [PRBS_LEN-1:0] lfsr_reg;

  // LFSR state: reseed on load, step one byte on advance
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr_reg <= ResetSeed;
    end else if (load) begin
      lfsr_reg <= seed;
    end else if (advance) begin
      lfsr_reg <= prbs15_advance8(lfsr_reg);
    end
  end

  // Feedback bits enter at s[0] and need 14 shifts to reach the output,
  // so the next eight output bits are simply the top eight state bits.
  assign data_byte = lfsr_reg[PRBS_TAP_HI -: 8];

endmodule

// File: rtl/prbs_frame_sequencer.sv
// Frame sequencer: emits nPattern copies of a 32-bit header (LSB byte first)
// followed by nPrbsBytes PRBS-15 bytes over a valid/ready byte stream.
module prbs_frame_sequencer
  import prbs_pkg::*;
#(
  parameter int                  BusWidth   = 8,
  parameter logic [31:0]         Pattern    = DEFAULT_PATTERN,
  parameter int                  nPattern   = 4,
  parameter int                  nPrbsBytes = 16,
  parameter logic [PRBS_LEN-1:0] Seed       = DEFAULT_SEED
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Start,
  input  logic                OutReady,
  output logic [BusWidth-1:0] OutData,
  output logic                OutValid,
  output logic                Busy,
  output logic                Done
);

  localparam logic [3:0] REP_LAST = 4'(nPattern - 1);
  localparam logic [7:0] PAY_LAST = 8'(nPrbsBytes - 1);

  state_t              state_reg, state_next;
  logic [1:0]          byte_idx_reg, byte_idx_next;
  logic [3:0]          rep_cnt_reg, rep_cnt_next;
  logic [7:0]          pay_cnt_reg, pay_cnt_next;
  logic [BusWidth-1:0] out_data_reg, out_data_next;
  logic                out_valid_reg, out_valid_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  logic                gen_load;
  logic                gen_advance;
  logic [7:0]          gen_byte;
  logic                xfer;
  logic [31:0]         pattern_word;
  logic [1:0]          idx_plus;
  logic [7:0]          hdr_byte_next;

  // The generator state always runs one byte ahead of OutData: it advances
  // whenever a payload byte is loaded into the output register.
  prbs15_byte_gen #(
    .ResetSeed(Seed)
  ) u_gen (
    .CLK      (CLK),
    .RST      (RST),
    .load     (gen_load),
    .advance  (gen_advance),
    .seed     (Seed),
    .data_byte(gen_byte)
  );

  assign xfer          = out_valid_reg & OutReady;
  assign pattern_word  = Pattern;
  assign idx_plus      = byte_idx_reg + 2'd1;
  assign hdr_byte_next = pattern_word[{idx_plus, 3'b000} +: 8];

  // State, counters and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      byte_idx_reg  <= '0;
      rep_cnt_reg   <= '0;
      pay_cnt_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      byte_idx_reg  <= byte_idx_next;
      rep_cnt_reg   <= rep_cnt_next;
      pay_cnt_reg   <= pay_cnt_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  // Next-state and next-output logic; a stalled byte simply holds
  always_comb begin
    state_next     = state_reg;
    byte_idx_next  = byte_idx_reg;
    rep_cnt_next   = rep_cnt_reg;
    pay_cnt_next   = pay_cnt_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    gen_load       = 1'b0;
    gen_advance    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        out_valid_next = 1'b0;
        busy_next      = 1'b0;
        if (Start) begin
          state_next     = ST_HEADER;
          byte_idx_next  = '0;
          rep_cnt_next   = '0;
          pay_cnt_next   = '0;
          gen_load       = 1'b1;
          out_data_next  = Pattern[7:0];
          out_valid_next = 1'b1;
          busy_next      = 1'b1;
        end
      end

      ST_HEADER: begin
        if (xfer) begin
          if (byte_idx_reg == 2'd3 && rep_cnt_reg == REP_LAST) begin
            state_next    = ST_PAYLOAD;
            out_data_next = gen_byte;
            gen_advance   = 1'b1;
          end else begin
            byte_idx_next = idx_plus;
            if (byte_idx_reg == 2'd3) begin
              rep_cnt_next = rep_cnt_reg + 4'd1;
            end
            out_data_next = hdr_byte_next;
          end
        end
      end

      ST_PAYLOAD: begin
        if (xfer) begin
          pay_cnt_next = pay_cnt_reg + 8'd1;
          if (pay_cnt_reg == PAY_LAST) begin
            state_next     = ST_FINISH;
            out_data_next  = '0;
            out_valid_next = 1'b0;
            busy_next      = 1'b0;
            done_next      = 1'b1;
          end else begin
            out_data_next = gen_byte;
            gen_advance   = 1'b1;
          end
        end
      end

      ST_FINISH: begin
        state_next     = ST_IDLE;
        out_valid_next = 1'b0;
        busy_next      = 1'b0;
      end

      default: begin
        state_next     = ST_IDLE;
        byte_idx_next  = '0;
        rep_cnt_next   = '0;
        pay_cnt_next   = '0;
        out_data_next  = '0;
        out_valid_next = 1'b0;
        busy_next      = 1'b0;
      end
    endcase
  end

  assign OutData  = out_data_reg;
  assign OutValid = out_valid_reg;
  assign Busy     = busy_reg;
  assign Done     = done_reg;

endmodule
